// File: rtl/uart_rx_ctrl.sv
// Receive-path controller: captures completed frames from uart_rx, pushes,
// drops or discards them, keeps saturating error counters, and raises a
// character-timeout interrupt when data sits in the FIFO on an idle line.
module uart_rx_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_enable,
  input  logic             i_drop_bad,
  input  logic [31:0]      i_bit_length,
  input  logic [7:0]       i_timeout_bits,
  input  logic             i_err_clr,
  input  logic             i_rx_done,
  input  logic [7:0]       i_rx_word,
  input  logic             i_rx_frame_error,
  input  logic             i_rx_parity_error,
  input  logic             i_rx_status,
  input  logic             i_fifo_full,
  input  logic             i_fifo_empty,
  input  logic             i_fifo_rd_en,
  output logic             o_fifo_wr_en,
  output logic [9:0]       o_fifo_wr_data,
  output logic             o_overrun,
  output logic             o_timeout_irq,
  output logic [CNT_W-1:0] o_frame_err_cnt,
  output logic [CNT_W-1:0] o_parity_err_cnt,
  output logic [CNT_W-1:0] o_overrun_cnt
);

  typedef enum logic [1:0] {StIdle, StPush, StDrop, StDiscard} state_e;

  state_e           state_q, state_d;
  logic [9:0]       wr_data_q, wr_data_d;
  logic             overrun_q, overrun_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] fe_cnt_q, fe_cnt_d;
  logic [CNT_W-1:0] pe_cnt_q, pe_cnt_d;
  logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic [31:0]      period_q, period_d;
  logic [7:0]       idle_bits_q, idle_bits_d;

  logic       capture;
  logic       lost;
  logic       drop_ovr;
  logic       wr_en;
  logic [1:0] ovr_inc;
  logic       armed;
  logic       tmo_clr;
  logic       irq_set;
  logic       irq_clr;

  // Add up to two events to a counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, val} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Frame handling: capture, overrun accounting and next FSM state.
  always_comb begin
    capture  = (state_q == StIdle) & i_enable & i_rx_done;
    // A frame arriving while the previous one is still being handled is lost.
    lost     = (state_q != StIdle) & i_enable & i_rx_done;
    drop_ovr = (state_q == StDrop) & i_enable;
    ovr_inc  = {1'b0, lost} + {1'b0, drop_ovr};
    wr_en    = (state_q == StPush) & i_enable;

    wr_data_d = capture ? {i_rx_parity_error, i_rx_frame_error, i_rx_word} : wr_data_q;

    state_d = StIdle;
    if (i_enable) begin
      unique case (state_q)
        StIdle: begin
          if (i_rx_done) begin
            if (i_fifo_full) begin
              state_d = StDrop;
            end else if (i_drop_bad & (i_rx_frame_error | i_rx_parity_error)) begin
              state_d = StDiscard;
            end else begin
              state_d = StPush;
            end
          end
        end
        StPush, StDrop, StDiscard: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // Clear first, then apply same-cycle events so they survive the clear.
    fe_cnt_d  = sat_add(i_err_clr ? '0 : fe_cnt_q, {1'b0, capture & i_rx_frame_error});
    pe_cnt_d  = sat_add(i_err_clr ? '0 : pe_cnt_q, {1'b0, capture & i_rx_parity_error});
    ovr_cnt_d = sat_add(i_err_clr ? '0 : ovr_cnt_q, ovr_inc);
    overrun_d = (i_err_clr ? 1'b0 : overrun_q) | (ovr_inc != 2'd0);
  end

  // Character timeout: count idle bit periods while data waits in the FIFO.
  always_comb begin
    armed   = i_enable & ~i_fifo_empty & ~i_rx_status & (i_timeout_bits != 8'd0);
    tmo_clr = ~armed | wr_en | i_fifo_rd_en | i_rx_status;

    period_d    = period_q;
    idle_bits_d = idle_bits_q;
    if (tmo_clr) begin
      period_d    = '0;
      idle_bits_d = '0;
    end else if (period_q == i_bit_length) begin
      period_d    = '0;
      idle_bits_d = (idle_bits_q == 8'hff) ? idle_bits_q : idle_bits_q + 8'd1;
    end else begin
      period_d = period_q + 32'd1;
    end

    irq_set = armed & (idle_bits_q == i_timeout_bits);
    irq_clr = i_fifo_rd_en | i_fifo_empty | wr_en | ~i_enable;
    irq_d   = irq_clr ? 1'b0 : (irq_set | irq_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= StIdle;
      wr_data_q   <= '0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
      fe_cnt_q    <= '0;
      pe_cnt_q    <= '0;
      ovr_cnt_q   <= '0;
      period_q    <= '0;
      idle_bits_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_data_q   <= wr_data_d;
      overrun_q   <= overrun_d;
      irq_q       <= irq_d;
      fe_cnt_q    <= fe_cnt_d;
      pe_cnt_q    <= pe_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
      period_q    <= period_d;
      idle_bits_q <= idle_bits_d;
    end
  end

  // Write strobe is dropped the moment the controller is disabled.
  assign o_fifo_wr_en     = wr_en;
  assign o_fifo_wr_data   = wr_data_q;
  assign o_overrun        = overrun_q;
  assign o_timeout_irq    = irq_q;
  assign o_frame_err_cnt  = fe_cnt_q;
  assign o_parity_err_cnt = pe_cnt_q;
  assign o_overrun_cnt    = ovr_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_uart_rx_ctrl;

  logic        clk;
  logic        nrst;
  logic        en, drop_bad, clr, rx_done, fe, pe, status, full, empty, rd;
  logic [31:0] bit_len;
  logic [7:0]  tmo_bits, word;

  logic        wr_a, ovr_a, irq_a;
  logic [9:0]  data_a;
  logic [15:0] fec_a, pec_a, ovc_a;
  logic        wr_b, ovr_b, irq_b;
  logic [9:0]  data_b;
  logic [1:0]  fec_b, pec_b, ovc_b;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_ctrl #(.CNT_W(16)) u_dut (
    .i_clk(clk), .i_nrst(nrst), .i_enable(en), .i_drop_bad(drop_bad),
    .i_bit_length(bit_len), .i_timeout_bits(tmo_bits), .i_err_clr(clr),
    .i_rx_done(rx_done), .i_rx_word(word), .i_rx_frame_error(fe),
    .i_rx_parity_error(pe), .i_rx_status(status), .i_fifo_full(full),
    .i_fifo_empty(empty), .i_fifo_rd_en(rd), .o_fifo_wr_en(wr_a),
    .o_fifo_wr_data(data_a), .o_overrun(ovr_a), .o_timeout_irq(irq_a),
    .o_frame_err_cnt(fec_a), .o_parity_err_cnt(pec_a), .o_overrun_cnt(ovc_a)
  );

  uart_rx_ctrl #(.CNT_W(2)) u_dut_w2 (
    .i_clk(clk), .i_nrst(nrst), .i_enable(en), .i_drop_bad(drop_bad),
    .i_bit_length(bit_len), .i_timeout_bits(tmo_bits), .i_err_clr(clr),
    .i_rx_done(rx_done), .i_rx_word(word), .i_rx_frame_error(fe),
    .i_rx_parity_error(pe), .i_rx_status(status), .i_fifo_full(full),
    .i_fifo_empty(empty), .i_fifo_rd_en(rd), .o_fifo_wr_en(wr_b),
    .o_fifo_wr_data(data_b), .o_overrun(ovr_b), .o_timeout_irq(irq_b),
    .o_frame_err_cnt(fec_b), .o_parity_err_cnt(pec_b), .o_overrun_cnt(ovc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_fate: what the most recently accepted frame does in the following cycle:
  // 0 nothing pending, 1 written to FIFO, 2 lost to a full FIFO, 3 thrown away.
  int          m_fate = 0;
  logic [9:0]  m_data = '0;
  int          m_fe = 0, m_pe = 0, m_ov = 0;
  bit          m_overrun = 0, m_irq = 0;
  longint      m_run = 0;   // consecutive armed, undisturbed cycles

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_fate = 0; m_data = '0; m_fe = 0; m_pe = 0; m_ov = 0;
    m_overrun = 0; m_irq = 0; m_run = 0;
  endtask

  task automatic model_step();
    bit     wr, armed, set, iclr;
    int     lost_frames;
    longint bits;
    wr = (m_fate == 1) && en;
    lost_frames = 0;
    if (en && m_fate == 2) lost_frames++;
    if (en && m_fate != 0 && rx_done) lost_frames++;
    if (clr) begin
      m_fe = 0; m_pe = 0; m_ov = 0; m_overrun = 0;
    end
    if (en && m_fate == 0 && rx_done) begin
      m_fe += int'(fe);
      m_pe += int'(pe);
      m_data = {pe, fe, word};
    end
    m_ov += lost_frames;
    if (lost_frames > 0) m_overrun = 1;

    bits  = m_run / (longint'(bit_len) + 1);
    if (bits > 255) bits = 255;
    armed = en && !empty && !status && (tmo_bits != 0);
    set   = armed && (bits == longint'(tmo_bits));
    iclr  = rd || empty || wr || !en;
    m_irq = iclr ? 1'b0 : (set ? 1'b1 : m_irq);
    m_run = (!armed || wr || rd) ? 0 : m_run + 1;

    if (!en || m_fate != 0 || !rx_done) m_fate = 0;
    else if (full) m_fate = 2;
    else if (drop_bad && (fe || pe)) m_fate = 3;
    else m_fate = 1;
  endtask

  // Single compare process: advance the model at each edge, check mid-cycle.
  always @(posedge clk) begin
    if (!nrst) model_reset();
    else model_step();
    #2;
    if (!nrst) model_reset();
    check("wr_en",        wr_a,   (m_fate == 1) && en);
    check("wr_data",      data_a, m_data);
    check("overrun",      ovr_a,  m_overrun);
    check("timeout_irq",  irq_a,  m_irq);
    check("frame_cnt",    fec_a,  sat(m_fe, 16));
    check("parity_cnt",   pec_a,  sat(m_pe, 16));
    check("overrun_cnt",  ovc_a,  sat(m_ov, 16));
    check("w2_wr_en",     wr_b,   (m_fate == 1) && en);
    check("w2_wr_data",   data_b, m_data);
    check("w2_irq",       irq_b,  m_irq);
    check("w2_frame_cnt", fec_b,  sat(m_fe, 2));
    check("w2_parity",    pec_b,  sat(m_pe, 2));
    check("w2_ovr_cnt",   ovc_b,  sat(m_ov, 2));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic frame(input logic [7:0] w, input logic f, input logic p);
    rx_done = 1'b1; word = w; fe = f; pe = p;
    cyc();
    rx_done = 1'b0; fe = 1'b0; pe = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"},   wr_a,   0);
    check({tag, "_data"}, data_a, 0);
    check({tag, "_ovr"},  ovr_a,  0);
    check({tag, "_irq"},  irq_a,  0);
    check({tag, "_fec"},  fec_a,  0);
    check({tag, "_pec"},  pec_a,  0);
    check({tag, "_ovc"},  ovc_a,  0);
  endtask

  initial begin
    int n;
    bit seen;
    nrst = 1'b0; en = 1'b1; drop_bad = 1'b0; clr = 1'b0; rx_done = 1'b0;
    fe = 1'b0; pe = 1'b0; status = 1'b0; full = 1'b0; empty = 1'b1; rd = 1'b0;
    bit_len = 32'd0; tmo_bits = 8'd0; word = 8'h00;
    repeat (3) cyc();
    settle();
    check_all_zero("reset");
    cyc();
    nrst = 1'b1;
    cyc();

    // Clean frame
    frame(8'hA5, 1'b0, 1'b0);
    settle();
    check("clean_wr", wr_a, 1);
    check("clean_data", data_a, 10'h0A5);
    cyc(); settle();
    check("clean_wr_once", wr_a, 0);
    check("clean_cnt", {fec_a, pec_a}, 0);

    // Errored frame, kept then discarded
    cyc();
    frame(8'h3C, 1'b1, 1'b1);
    settle();
    check("err_keep_wr", wr_a, 1);
    check("err_keep_data", data_a, 10'h33C);
    check("err_keep_cnt", {fec_a, pec_a}, {16'd1, 16'd1});
    cyc();
    drop_bad = 1'b1;
    frame(8'h3C, 1'b1, 1'b1);
    settle();
    check("err_drop_wr", wr_a, 0);
    check("err_drop_cnt", {fec_a, pec_a}, {16'd2, 16'd2});
    cyc();

    // Overrun on a full FIFO
    full = 1'b1;
    frame(8'h11, 1'b0, 1'b0);
    settle();
    check("ovr_wr", wr_a, 0);
    cyc(); settle();
    check("ovr_flag", ovr_a, 1);
    check("ovr_cnt", ovc_a, 1);
    frame(8'h22, 1'b0, 1'b0);
    clr = 1'b1;
    cyc();
    clr = 1'b0; full = 1'b0;
    settle();
    check("clr_ovr_cnt", ovc_a, 1);
    check("clr_ovr_flag", ovr_a, 1);
    check("clr_pe_cnt", pec_a, 0);

    // Saturation on the narrow instance
    for (int i = 0; i < 5; i++) begin
      frame(8'h40 + 8'(i), 1'b0, 1'b1);
      cyc();
    end
    settle();
    check("sat_pe_w2", pec_b, 3);
    check("sat_pe_w16", pec_a, 5);
    drop_bad = 1'b0;

    // Character timeout
    bit_len = 32'd9; tmo_bits = 8'd4; empty = 1'b0;
    n = 0;
    do begin cyc(); settle(); n++; end while (!irq_a && n < 200);
    check("tmo_latency", n, 41);
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    settle();
    check("tmo_rd_clear", irq_a, 0);
    n = 0;
    do begin cyc(); settle(); n++; end while (!irq_a && n < 200);
    check("tmo_restart", n, 41);
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (i >= 30) status = 1'b1;
      settle();
      if (irq_a) seen = 1'b1;
      cyc();
    end
    check("tmo_busy_noirq", seen, 0);
    status = 1'b0; empty = 1'b1; tmo_bits = 8'd0;
    cyc();

    // Disable during PUSH
    frame(8'h55, 1'b0, 1'b0);
    en = 1'b0;
    settle();
    check("dis_push_wr", wr_a, 0);
    cyc();
    en = 1'b1;
    settle();
    check("dis_push_after", wr_a, 0);
    cyc();

    // Reset during DROP
    full = 1'b1;
    frame(8'h66, 1'b0, 1'b0);
    nrst = 1'b0;
    settle();
    check_all_zero("rst_drop");
    cyc();
    nrst = 1'b1; full = 1'b0;
    settle();
    check("rst_drop_ovr", ovr_a, 0);
    cyc();
    frame(8'h77, 1'b0, 1'b0);
    settle();
    check("rst_then_push", {wr_a, data_a}, {1'b1, 10'h077});
    cyc();

    // Randomized traffic
    bit_len = 32'd1; tmo_bits = 8'd2;
    for (int i = 0; i < 4000; i++) begin
      nrst     = ($urandom_range(0, 399) != 0);
      en       = ($urandom_range(0, 49) != 0);
      if (!en) bit_len = 32'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) tmo_bits = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) empty = ~empty;
      if ($urandom_range(0, 49) == 0) drop_bad = ~drop_bad;
      rx_done  = ($urandom_range(0, 3) == 0);
      word     = 8'($urandom);
      fe       = ($urandom_range(0, 3) == 0);
      pe       = ($urandom_range(0, 3) == 0);
      full     = ($urandom_range(0, 5) == 0);
      clr      = ($urandom_range(0, 39) == 0);
      rd       = ($urandom_range(0, 39) == 0);
      status   = ($urandom_range(0, 29) == 0);
      cyc();
    end
    nrst = 1'b1; en = 1'b1; rx_done = 1'b0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
